muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage. It generalises the fixed 32-bit divider into one parametrised engine that handles signed and unsigned multiply and divide. The unit latches its operands on `start` and raises `stall_req` while it works. When finished it pulses `done` and holds `{hi, lo}` for the HI/LO write path.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_absneg.sv | 13 +
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings and FSM state enum.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and final sign fix-up.
module muldiv_absneg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide for EX.
// Optional MDU_DIV_EARLY_TERM_EN skips CALC when |dividend| < |divisor|.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic               stall_req
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q;

  logic [WIDTH-1:0]   ma_q, mb_q, hi_q, lo_q;
  logic               sa_q, sb_q, dz_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic               div_zero_q;

  logic             idle_or_done, accept, early;
  logic             in_div, in_signed, in_sa, in_sb, in_dz;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             q_div;

  assign idle_or_done = (state_q == MDU_IDLE) ||
                        (state_q == MDU_DONE);
  assign accept    = idle_or_done & start & ~annul;
  assign in_div    = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  assign in_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  assign in_sa     = in_signed & opdata1[WIDTH-1];
  assign in_sb     = in_signed & opdata2[WIDTH-1];
  assign in_dz     = in_div & (opdata2 == '0);
  assign q_div     = (op_q == MDU_OP_DIV) || (op_q == MDU_OP_DIVU);

  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
    .neg (in_sa),
    .a   (opdata1),
    .y   (abs_a)
  );

  muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
    .neg (in_sb),
    .a   (opdata2),
    .y   (abs_b)
  );

`ifdef MDU_DIV_EARLY_TERM_EN
  assign early = in_div & ~in_dz & (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // Shared adder: mul adds multiplicand to hi, div trial-subtracts divisor
  logic [WIDTH:0]   as_a, as_b;
  logic [WIDTH+1:0] as_sum;

  assign as_a   = q_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
  assign as_b   = q_div ? ~{1'b0, mb_q} : {1'b0, ma_q};
  assign as_sum = {1'b0, as_a} + {q_div, as_b} +
                  {{(WIDTH+1){1'b0}}, q_div};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] fix_res;

  muldiv_absneg #(.WIDTH(2*WIDTH)) u_neg_prod (
    .neg (sa_q ^ sb_q),
    .a   ({hi_q, lo_q}),
    .y   (prod_fix)
  );

  muldiv_absneg #(.WIDTH(WIDTH)) u_neg_quo (
    .neg (sa_q ^ sb_q),
    .a   (lo_q),
    .y   (quo_fix)
  );

  muldiv_absneg #(.WIDTH(WIDTH)) u_neg_rem (
    .neg (sa_q),
    .a   (hi_q),
    .y   (rem_fix)
  );

  always_comb begin
    fix_res = prod_fix;
    if (q_div)
      fix_res = {rem_fix, dz_q ? {WIDTH{1'b1}} : quo_fix};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE, MDU_DONE: begin
        state_d = MDU_IDLE;
        if (accept)
          state_d = early ? MDU_FIX : MDU_CALC;
      end
      MDU_CALC: begin
        if (annul)
          state_d = MDU_IDLE;
        else if (cnt_q == '0)
          state_d = MDU_FIX;
      end
      MDU_FIX:
        state_d = annul ? MDU_IDLE : MDU_DONE;
      default:
        state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= MDU_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= MDU_OP_MULT;
      ma_q       <= '0;
      mb_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= mdu_op_e'(op);
        ma_q  <= abs_a;
        mb_q  <= abs_b;
        sa_q  <= in_sa;
        sb_q  <= in_sb;
        dz_q  <= in_dz;
        cnt_q <= CW'(WIDTH - 1);
        hi_q  <= early ? abs_a : '0;
        lo_q  <= early ? '0 : (in_div ? abs_a : abs_b);
      end else if (state_q == MDU_CALC) begin
        cnt_q <= cnt_q - 1'b1;
        if (q_div) begin
          if (!as_sum[WIDTH+1]) begin
            hi_q <= as_sum[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= as_a[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          hi_q <= as_sum[WIDTH:1];
          lo_q <= {as_sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_q <= {1'b0, hi_q[WIDTH-1:1]};
          lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end
      if (state_q == MDU_FIX && !annul) begin
        result_q   <= fix_res;
        div_zero_q <= dz_q;
      end
    end
  end

  assign busy      = (state_q == MDU_CALC) || (state_q == MDU_FIX);
  assign done      = (state_q == MDU_DONE);
  assign result    = result_q;
  assign div_zero  = div_zero_q;
  assign stall_req = accept | busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Expected results are hand-computed constants.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MDU_DIV_EARLY_TERM_EN
  localparam int LAT_SHORT = 2;
`else
  localparam int LAT_SHORT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        annul;
  logic [31:0] opdata1, opdata2;
  logic        busy, done, div_zero, stall_req;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .annul     (annul),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .div_zero  (div_zero),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Call at a negedge: drives start for one rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    op = o;
    opdata1 = a;
    opdata2 = b;
    #1;
    chk("stall_at_T", {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after accept until done; optional stray start pulse
  task automatic wait_done(input int pulse_at, output int l);
    int bad;
    bad = 0;
    l = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        l = n;
        if (stall_req) bad++;
        break;
      end
      if (!stall_req) bad++;
      if (n == pulse_at) begin
        start = 1'b1;
        op = OP_DIVU;
        opdata1 = 32'd9;
        opdata2 = 32'd2;
      end
      if (n == pulse_at + 1) start = 1'b0;
    end
    chk("stall_window", 64'(bad), 64'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int exp_lat);
    @(negedge clk);
    issue(o, a, b);
    wait_done(-1, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall_req}, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_dz"}, {63'd0, div_zero}, 64'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    op = 2'b00;
    opdata1 = '0;
    opdata2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");

    run("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'h0000_0000_0000_0001, 34);
    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001, 34);
    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5,
        64'hFFFF_FFFF_FFFF_FFF1, 34);
    run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 34);
    run("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
        64'h0000_0001_FFFF_FFFD, 34);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        64'h0000_0000_8000_0000, 34);
    chk("ovf_dz", {63'd0, div_zero}, 64'd0);
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7,
        64'h0000_0002_0000_000E, 34);
    run("divu_5_7", OP_DIVU, 32'd5, 32'd7,
        64'h0000_0005_0000_0000, LAT_SHORT);
    run("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0,
        64'hFFFF_FFF9_FFFF_FFFF, 34);
    chk("dz_flag", {63'd0, div_zero}, 64'd1);

    // Annul in CALC at T+10
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    chk("annul_busy", {63'd0, busy}, 64'd0);
    chk("annul_stall", {63'd0, stall_req}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("annul_nodone", 64'(ndone), 64'd0);
    chk("annul_res", result, 64'hFFFF_FFF9_FFFF_FFFF);
    chk("annul_dz", {63'd0, div_zero}, 64'd1);

    // start with annul in IDLE is not accepted
    @(negedge clk);
    start = 1'b1;
    annul = 1'b1;
    op = OP_MULTU;
    opdata1 = 32'd6;
    opdata2 = 32'd7;
    #1 chk("sa_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    chk("sa_busy", {63'd0, busy}, 64'd0);

    // stray start at T+5 while busy
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(5, lat);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_res", result, 64'd12);

    // Back-to-back: accept in DONE cycle
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(-1, lat);
    chk("b2b1_lat", 64'(lat), 64'd34);
    chk("b2b1_res", result, 64'd12);
    issue(OP_DIVU, 32'd9, 32'd2);
    wait_done(-1, lat);
    chk("b2b2_lat", 64'(lat), 64'd34);
    chk("b2b2_res", result, 64'h0000_0001_0000_0004);

    // Reset at T+20
    @(negedge clk);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_zero("midrst");

    run("post_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
        64'h0000_0001_0000_0000, 34);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
